imem_loader: RTL

//   Writer side of the instruction memory. Accepts a byte stream from a host port
//   and packs it, little-endian, into 32-bit instruction words.

---
 rtl/imem_loader.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. A host pushes a byte stream with a
//   valid/ready handshake. The loader packs every four bytes little-endian
//   (first byte lands in the LSB lane) into one instruction word. It writes
//   each word into the instruction RAM at BASE_ADDR + 4*n. While a load is in
//   progress, cpu_hold keeps the CPU off the fetch port so that it never sees
//   a half-written image.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       begin a load (only looked at while idle)
//   load_len    number of words to load, captured together with start
//   abort       cancel the load in progress (receive or write phase)
//   byte_valid  host byte present on byte_data
//   byte_data   stream byte
//   byte_ready  loader accepts byte_data this cycle (state-only, never
//               combinationally dependent on byte_valid)
//   we          one-cycle write strobe to the instruction RAM
//   waddr       4-aligned byte address of the word being written
//   wdata       packed word {b3,b2,b1,b0}
//   cpu_hold    high whenever the loader is not idle
//   done        one-cycle pulse after the last requested word is written
//   err         one-cycle pulse for a rejected length or an abort
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int                     BYTE        = 8,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     ROM_DEPTH   = 256,
  parameter logic [INSTR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                     LEN_W       = 7
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_W-1:0]       load_len,
  input  logic                   abort,
  input  logic                   byte_valid,
  input  logic [BYTE-1:0]        byte_data,
  output logic                   byte_ready,
  output logic                   we,
  output logic [INSTR_WIDTH-1:0] waddr,
  output logic [INSTR_WIDTH-1:0] wdata,
  output logic                   cpu_hold,
  output logic                   done,
  output logic                   err
);

  localparam int LANES = INSTR_WIDTH / BYTE;
  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

  // Largest word count that still fits inside the instruction memory.
  localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(ROM_DEPTH / LANES);

  // Byte-address step between consecutive words.
  localparam logic [INSTR_WIDTH-1:0] WORD_STEP = INSTR_WIDTH'(LANES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q,   idx_d;
  logic [LEN_W-1:0]       count_q, count_d;
  logic [LEN_W-1:0]       len_q,   len_d;
  logic [INSTR_WIDTH-1:0] waddr_q, waddr_d;
  logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
  logic                   err_q,   err_d;

  // Count after the word currently being written has been committed.
  logic [LEN_W-1:0]       count_inc;
  assign count_inc = count_q + LEN_W'(1);

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      waddr_q <= BASE_ADDR;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      len_q   <= len_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    count_d = count_q;
    len_d   = len_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (load_len == '0) begin
            // Empty image: report completion without touching memory.
            state_d = S_DONE;
          end else if (load_len > MAX_WORDS) begin
            // Would overrun the memory: refuse and stay idle.
            err_d = 1'b1;
          end else begin
            state_d = S_RECV;
            len_d   = load_len;
            count_d = '0;
            idx_d   = '0;
            waddr_d = BASE_ADDR;
          end
        end
      end

      S_RECV: begin
        if (abort) begin
          // Any partially assembled word is dropped; the next load starts at lane 0.
          state_d = S_IDLE;
          err_d   = 1'b1;
          idx_d   = '0;
        end else if (byte_valid) begin
          // Lanes are overwritten in place; stale bytes from the previous word
          // are never visible because the write waits for all lanes.
          for (int l = 0; l < LANES; l++) begin
            if (idx_q == IDX_W'(l)) begin
              wdata_d[l*BYTE +: BYTE] = byte_data;
            end
          end
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(LANES - 1)) begin
            state_d = S_WRITE;
          end
        end
      end

      S_WRITE: begin
        // The strobe for this cycle is issued regardless of abort.
        if (abort) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          waddr_d = waddr_q + WORD_STEP;
          count_d = count_inc;
          state_d = (count_inc == len_q) ? S_DONE : S_RECV;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  assign byte_ready = (state_q == S_RECV);
  assign we         = (state_q == S_WRITE);
  assign cpu_hold   = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign waddr      = waddr_q;
  assign wdata      = wdata_q;

endmodule
